// File: rtl/image_loader.sv
// rtl/image_loader.sv - packs a grayscale pixel byte stream into 128-bit words for a downstream FIFO
module image_loader #(
  parameter int IMAGE_WIDTH  = 100,
  parameter int IMAGE_HEIGHT = 100
) (
  input  logic         clk_pixel,
  input  logic         image_loader_reset,
  input  logic         start,
  input  logic         abort,
  input  logic [7:0]   s_pixel_data,
  input  logic         s_pixel_valid,
  output logic         s_pixel_ready,
  input  logic         image_sender_full,
  output logic         image_sender_write,
  output logic [127:0] image_sender_fifo_din,
  output logic         image_sender_flush,
  output logic         busy,
  output logic         done,
  output logic [15:0]  word_count
);

  localparam int PIXELS = IMAGE_WIDTH * IMAGE_HEIGHT;
  localparam int WORDS  = (PIXELS + 15) / 16;
  localparam int PCW    = $clog2(PIXELS + 1);

  generate
    if (WORDS >= 65536) begin : g_words_check
      $error("image_loader: WORDS does not fit the 16-bit word_count");
    end
  endgenerate

  typedef enum logic [2:0] {S_IDLE, S_FLUSH, S_PACK, S_WRITE, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [127:0]     word_q, word_d;
  logic [3:0]       idx_q, idx_d;
  logic [PCW-1:0]   pix_q, pix_d;
  logic [15:0]      wc_q, wc_d;

  always_ff @(posedge clk_pixel or posedge image_loader_reset) begin
    if (image_loader_reset) begin
      state_q <= S_IDLE;
      word_q  <= '0;
      idx_q   <= '0;
      pix_q   <= '0;
      wc_q    <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      idx_q   <= idx_d;
      pix_q   <= pix_d;
      wc_q    <= wc_d;
    end
  end

  // abort overrides every transition; a partially packed word is discarded
  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    idx_d   = idx_q;
    pix_d   = pix_q;
    wc_d    = wc_q;
    if (abort) begin
      state_d = S_IDLE;
      word_d  = '0;
      idx_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d = S_FLUSH;
            word_d  = '0;
            idx_d   = '0;
            pix_d   = '0;
            wc_d    = '0;
          end
        end
        S_FLUSH: state_d = S_PACK;
        S_PACK: begin
          if (s_pixel_valid) begin
            word_d[{idx_q, 3'b000} +: 8] = s_pixel_data;
            idx_d = idx_q + 4'd1;
            pix_d = pix_q + PCW'(1);
            if (idx_q == 4'd15 || pix_q == PCW'(PIXELS - 1)) state_d = S_WRITE;
          end
        end
        S_WRITE: begin
          if (!image_sender_full) begin
            wc_d    = wc_q + 16'd1;
            word_d  = '0;
            idx_d   = '0;
            state_d = (wc_q + 16'd1 == 16'(WORDS)) ? S_DONE : S_PACK;
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    s_pixel_ready      = (state_q == S_PACK);
    image_sender_write = (state_q == S_WRITE) && !image_sender_full && !abort;
    image_sender_flush = (state_q == S_FLUSH) && !abort;
    busy               = (state_q != S_IDLE);
    done               = (state_q == S_DONE);
  end

  assign image_sender_fifo_din = word_q;
  assign word_count            = wc_q;

endmodule

// File: tb/tb_image_loader.sv
// tb/tb_image_loader.sv - self-checking bench for image_loader (100x100 and 3x7 instances)
module tb_image_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, start, abort, valid, full;
  logic [7:0]   data;
  logic         ready1, wr1, flush1, busy1, done1;
  logic [127:0] din1;
  logic [15:0]  wc1;
  logic         ready2, wr2, flush2, busy2, done2;
  logic [127:0] din2;
  logic [15:0]  wc2;

  image_loader #(.IMAGE_WIDTH(100), .IMAGE_HEIGHT(100)) dut1 (
    .clk_pixel(clk), .image_loader_reset(rst), .start(start), .abort(abort),
    .s_pixel_data(data), .s_pixel_valid(valid), .s_pixel_ready(ready1),
    .image_sender_full(full), .image_sender_write(wr1), .image_sender_fifo_din(din1),
    .image_sender_flush(flush1), .busy(busy1), .done(done1), .word_count(wc1));

  image_loader #(.IMAGE_WIDTH(3), .IMAGE_HEIGHT(7)) dut2 (
    .clk_pixel(clk), .image_loader_reset(rst), .start(start), .abort(abort),
    .s_pixel_data(data), .s_pixel_valid(valid), .s_pixel_ready(ready2),
    .image_sender_full(full), .image_sender_write(wr2), .image_sender_fifo_din(din2),
    .image_sender_flush(flush2), .busy(busy2), .done(done2), .word_count(wc2));

  int checks, failures;
  int n;
  bit gaps;

  // output monitor, sampled on the falling edge
  logic [127:0] words1 [625];
  logic [127:0] words2 [2];
  int  writes1 = 0, writes2 = 0, flushes1 = 0, dones1 = 0, dones2 = 0, consec1 = 0, rdy_viol = 0;
  logic prev_wr1 = 1'b0;
  logic [15:0] wc_done1 = '0, wc_done2 = '0;
  time t_first = 0, t_last = 0;

  always @(negedge clk) begin
    prev_wr1 <= wr1;
    if (wr1) begin
      if (wc1 < 16'd625) words1[wc1] <= din1;
      writes1 <= writes1 + 1;
      if (prev_wr1) consec1 <= consec1 + 1;
      if (wc1 == 16'd0) t_first <= $time;
      if (wc1 == 16'd624) t_last <= $time;
    end
    if (wr2) begin
      words2[wc2[0]] <= din2;
      writes2 <= writes2 + 1;
    end
    if (flush1) flushes1 <= flushes1 + 1;
    if (done1) begin dones1 <= dones1 + 1; wc_done1 <= wc1; end
    if (done2) begin dones2 <= dones2 + 1; wc_done2 <= wc2; end
    if (ready1 && (!busy1 || wr1 || flush1 || done1)) rdy_viol <= rdy_viol + 1;
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] mword(input int k);
    logic [127:0] w;
    for (int j = 0; j < 16; j++) w[8*j +: 8] = 8'((16*k + j) % 256);
    return w;
  endfunction

  // one clock: the byte on the bus is consumed if dut1 is ready, then present the next one
  task automatic cyc();
    logic acc;
    acc = valid && ready1;
    @(posedge clk); #1;
    if (acc) n++;
    start = 1'b0;
    abort = 1'b0;
    data  = 8'(n % 256);
    valid = (n < 10000) && (!gaps || $urandom_range(0, 99) < 30);
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; abort = 1'b0; valid = 1'b0; full = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    n = 0;
  endtask

  typedef struct packed {
    logic       st;
    logic       ab;
    logic       vl;
    logic [4:0] exp;  // {busy, ready, flush, write, done}
  } vec_t;

  vec_t tbl [14];
  int   bw, bf, bd, bd2, bw2, bad, guard;
  logic [127:0] cap;

  initial begin
    checks = 0; failures = 0; n = 0; gaps = 1'b0;
    rst = 1'b0; start = 1'b0; abort = 1'b0; valid = 1'b0; full = 1'b0; data = '0;
    #1 rst = 1'b1;
    #1;
    chk("reset_ctrl1", {busy1, ready1, flush1, wr1, done1}, 0);
    chk("reset_wc1", wc1, 0);
    chk("reset_din1", din1, 0);
    chk("reset_ctrl2", {busy2, ready2, flush2, wr2, done2, wc2}, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // control sequence: start/abort priority, flush pulse, ready only in PACK
    tbl[0]  = '{1'b0, 1'b0, 1'b0, 5'b00000};
    tbl[1]  = '{1'b1, 1'b1, 1'b0, 5'b00000};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 5'b00000};
    tbl[3]  = '{1'b1, 1'b0, 1'b1, 5'b00000};
    tbl[4]  = '{1'b1, 1'b0, 1'b1, 5'b10100};
    tbl[5]  = '{1'b1, 1'b0, 1'b0, 5'b11000};
    tbl[6]  = '{1'b0, 1'b0, 1'b1, 5'b11000};
    tbl[7]  = '{1'b0, 1'b1, 1'b1, 5'b11000};
    tbl[8]  = '{1'b0, 1'b0, 1'b1, 5'b00000};
    tbl[9]  = '{1'b1, 1'b0, 1'b0, 5'b00000};
    tbl[10] = '{1'b0, 1'b1, 1'b0, 5'b10000};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 5'b00000};
    tbl[12] = '{1'b1, 1'b0, 1'b0, 5'b00000};
    tbl[13] = '{1'b0, 1'b0, 1'b0, 5'b10100};
    for (int i = 0; i < 14; i++) begin
      start = tbl[i].st; abort = tbl[i].ab; valid = tbl[i].vl; data = 8'(i);
      #1;
      chk($sformatf("ctrl_row%0d", i), {busy1, ready1, flush1, wr1, done1}, tbl[i].exp);
      @(posedge clk); #1;
    end

    // nominal stream of 10000 bytes; dut2 sees the first 21 bytes as its whole image
    do_reset();
    gaps = 1'b0;
    bw = writes1; bf = flushes1; bd = dones1; bw2 = writes2; bd2 = dones2;
    start = 1'b1;
    cyc();
    guard = 0;
    while (dones1 == bd && guard < 12000) begin cyc(); guard++; end
    chk("nom_timeout", guard < 12000, 1);
    cyc();
    chk("nom_writes", writes1 - bw, 625);
    chk("nom_flushes", flushes1 - bf, 1);
    chk("nom_dones", dones1 - bd, 1);
    chk("nom_wc_at_done", wc_done1, 625);
    chk("nom_wc_hold", wc1, 625);
    chk("nom_word0", words1[0], 128'h0F0E0D0C0B0A09080706050403020100);
    chk("nom_word1", words1[1], 128'h1F1E1D1C1B1A19181716151413121110);
    chk("nom_word15", words1[15], 128'hFFFEFDFCFBFAF9F8F7F6F5F4F3F2F1F0);
    chk("nom_word16", words1[16], 128'h0F0E0D0C0B0A09080706050403020100);
    chk("nom_word624", words1[624], 128'h0F0E0D0C0B0A09080706050403020100);
    bad = 0;
    for (int k = 0; k < 625; k++) if (words1[k] !== mword(k)) bad++;
    chk("nom_all_words_bad", bad, 0);
    chk("nom_throughput", t_last - t_first, 624 * 170);
    chk("part_writes", writes2 - bw2, 2);
    chk("part_word0", words2[0], 128'h0F0E0D0C0B0A09080706050403020100);
    chk("part_word1", words2[1], 128'h00000000000000000000001413121110);
    chk("part_dones", dones2 - bd2, 1);
    chk("part_wc_at_done", wc_done2, 2);

    // backpressure during the write of word 3
    do_reset();
    bw = writes1;
    start = 1'b1;
    cyc();
    guard = 0;
    while (writes1 - bw < 3 && guard < 200) begin cyc(); guard++; end
    full = 1'b1;
    while (!(busy1 && !ready1 && !flush1 && !done1) && guard < 300) begin cyc(); guard++; end
    chk("bp_timeout", guard < 300, 1);
    cap = din1;
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      if (wr1 || din1 !== cap || wc1 != 16'd3) bad++;
      cyc();
    end
    chk("bp_stall_bad", bad, 0);
    full = 1'b0;
    #1;
    chk("bp_release_write", wr1, 1);
    chk("bp_wc_before", wc1, 3);
    cyc();
    chk("bp_wc_after", wc1, 4);
    chk("bp_single_write", writes1 - bw, 4);
    chk("bp_word3", words1[3], 128'h3F3E3D3C3B3A39383736353433323130);
    abort = 1'b1;
    cyc();

    // abort in the middle of word 2, then restart
    do_reset();
    bw = writes1;
    start = 1'b1;
    cyc();
    guard = 0;
    while (n < 40 && guard < 200) begin cyc(); guard++; end
    abort = 1'b1;
    cyc();
    chk("abort_busy", {busy1, ready1}, 0);
    for (int k = 0; k < 30; k++) cyc();
    chk("abort_writes", writes1 - bw, 2);
    chk("abort_wc_hold", wc1, 2);
    bf = flushes1;
    start = 1'b1;
    cyc();
    chk("restart_flush", flush1, 1);
    chk("restart_wc", wc1, 0);
    abort = 1'b1;
    cyc();

    // asynchronous reset while a write is being presented
    do_reset();
    start = 1'b1;
    cyc();
    guard = 0;
    while (!wr1 && guard < 100) begin cyc(); guard++; end
    chk("rst_reach_write", wr1, 1);
    #2 rst = 1'b1;
    #1;
    chk("rst_async_ctrl", {busy1, ready1, flush1, wr1, done1}, 0);
    chk("rst_async_data", {wc1, din1}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    bw = writes1; bf = flushes1;
    for (int k = 0; k < 40; k++) cyc();
    chk("rst_no_write", writes1 - bw, 0);
    chk("rst_no_flush", flushes1 - bf, 0);
    chk("rst_idle", busy1, 0);

    // sparse source: same words as the continuous stream
    do_reset();
    gaps = 1'b1;
    bw = writes1; bd = dones1;
    start = 1'b1;
    cyc();
    guard = 0;
    while (dones1 == bd && guard < 60000) begin cyc(); guard++; end
    chk("gap_timeout", guard < 60000, 1);
    cyc();
    chk("gap_writes", writes1 - bw, 625);
    bad = 0;
    for (int k = 0; k < 625; k++) if (words1[k] !== mword(k)) bad++;
    chk("gap_all_words_bad", bad, 0);
    chk("ready_outside_pack", rdy_viol, 0);
    chk("consecutive_writes", consec1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/image_loader.md
IMAGE_LOADER -- requirements
Module: image_loader

Interface
REQ-001 Parameters SHALL be:
- IMAGE_WIDTH, 100, image width in pixels.
- IMAGE_HEIGHT, 100, image height in pixels.
- PIXELS = IMAGE_WIDTH*IMAGE_HEIGHT (derived).
- WORDS = ceil(PIXELS/16) (derived; 625 at defaults).
REQ-002 Ports SHALL be:
- clk_pixel  in  1  sole clock; all logic on its rising edge.
- image_loader_reset  in  1  reset, asynchronous, active-high.
- start  in  1  one-cycle pulse that begins loading one image.
- abort  in  1  one-cycle pulse that cancels loading.
- s_pixel_data  in  8  grayscale pixel byte.
- s_pixel_valid  in  1  pixel byte present.
- s_pixel_ready  out  1  loader accepts the byte this cycle.
- image_sender_full  in  1  downstream FIFO prog_full.
- image_sender_write  out  1  write strobe to downstream FIFO.
- image_sender_fifo_din  out  128  packed word.
- image_sender_flush  out  1  downstream FIFO flush pulse.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the image is complete.
- word_count  out  16  words written for the current image.

Function
REQ-003 The FSM SHALL have exactly five states: IDLE, FLUSH, PACK, WRITE, DONE.
REQ-004 IDLE + start SHALL go to FLUSH, clearing word_count, pixel count and byte index.
REQ-005 FLUSH SHALL last exactly one cycle, with image_sender_flush=1 only in that cycle, then go to PACK.
REQ-006 In PACK, s_pixel_ready SHALL be 1; in every other state it SHALL be 0.
REQ-007 A byte SHALL be accepted only when s_pixel_valid && s_pixel_ready.
REQ-008 The accepted byte SHALL be stored at word bits [8*i+7:8*i], where i is the byte index (0..15). The first byte of a word goes to bits [7:0].
REQ-009 After each accepted byte, the byte index SHALL increment modulo 16 and the pixel count SHALL increment.
REQ-010 PACK SHALL go to WRITE on accepting byte index 15, or on accepting pixel number PIXELS, whichever comes first.
REQ-011 On a partial last word, unfilled bytes SHALL be 0x00.
REQ-012 In WRITE, image_sender_fifo_din SHALL hold the packed word stable.
REQ-013 image_sender_write SHALL equal (state==WRITE && !image_sender_full), decoded from the state register with no added latency.
REQ-014 WRITE SHALL stay in WRITE while image_sender_full=1, with no write and no data change.
REQ-015 The cycle the write occurs, word_count SHALL increment. The next state SHALL be DONE if the new count equals WORDS, otherwise PACK, with the byte index and packing register cleared to 0.
REQ-016 Exactly one write SHALL occur per word; there are never two consecutive write cycles.
REQ-017 DONE SHALL last one cycle with done=1, then go to IDLE; word_count SHALL hold its value until the next start.
REQ-018 abort SHALL take priority over every other event in every state: next state IDLE, partial word discarded, no write in that cycle, and no flush.
REQ-019 start outside IDLE SHALL be ignored.
REQ-020 start and abort in the same cycle in IDLE SHALL leave the FSM in IDLE.
REQ-021 s_pixel_valid SHALL have no effect outside PACK; bytes offered there are not consumed.
REQ-022 word_count SHALL saturate-free wrap at 16 bits. This is unreachable since WORDS < 65536, which is checked by an elaboration assertion.
REQ-023 Throughput SHALL be 17 cycles per word when the source streams continuously and full=0.

Reset
REQ-024 image_loader_reset SHALL asynchronously force state=IDLE and set these to 0: s_pixel_ready, image_sender_write, image_sender_flush, busy, done, word_count, image_sender_fifo_din, byte index and pixel count.
REQ-025 Reset asserted mid-operation SHALL drop all buffered data. The first cycle after deassertion SHALL be IDLE with no spurious write or flush.

Verification
REQ-026 Nominal: start, stream 10000 bytes with values (n mod 256), full=0 -> one flush pulse; 625 writes, word 0 = 0x0F0E...0100; done pulses once with word_count=625.
REQ-027 Backpressure: hold full=1 for 20 cycles during WRITE of word 3 -> write=0 and din stable for those 20 cycles; exactly one write when full drops; word_count goes 3->4.
REQ-028 Partial word: IMAGE_WIDTH=3, IMAGE_HEIGHT=7 (21 pixels) -> 2 writes; second word bytes 0..4 hold data, bytes 5..15 are 0x00; done after write 2.
REQ-029 Abort: abort after 40 bytes (mid word 2) -> IDLE next cycle, busy=0, no further write; a subsequent start flushes and restarts with word_count=0.
REQ-030 Reset: assert image_loader_reset asynchronously mid-WRITE with full=0 -> write drops immediately without a clock edge; all outputs 0; no write after release.
REQ-031 Source gaps: random s_pixel_valid at 30% duty -> the word contents are identical to the REQ-026 case; ready=0 in every non-PACK cycle.
